// File: rtl/mips_defs.sv
// Shared encodings for the multi-cycle MIPS controller and the datapath muxes
// it steers: FSM state codes, instruction classes, opcode/funct values and
// the select encodings seen on the controller outputs.
package mips_defs;

  // FSM state codes
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  // Instruction classes produced by instr_decode
  typedef enum logic [3:0] {
    C_ILLEGAL = 4'd0,
    C_ADDU    = 4'd1,
    C_SUBU    = 4'd2,
    C_ORI     = 4'd3,
    C_LW      = 4'd4,
    C_SW      = 4'd5,
    C_BEQ     = 4'd6,
    C_LUI     = 4'd7,
    C_J       = 4'd8,
    C_JAL     = 4'd9,
    C_JR      = 4'd10
  } instr_class_t;

  // Opcode field, instr[31:26]
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  // Funct field for R-type, instr[5:0]
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // Next-PC select
  localparam logic [2:0] NPC_PC4    = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_REG    = 3'b011;

  // ALU operation
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

  // Immediate extension
  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  // Register-file destination select
  localparam logic [2:0] RD_RT = 3'b000;
  localparam logic [2:0] RD_RD = 3'b001;
  localparam logic [2:0] RD_RA = 3'b010;

  // ALU B-operand select
  localparam logic [2:0] SRC_RD2 = 3'b000;
  localparam logic [2:0] SRC_IMM = 3'b001;

  // Register-file write-data select
  localparam logic [2:0] TOREG_ALU = 3'b000;
  localparam logic [2:0] TOREG_DM  = 3'b001;
  localparam logic [2:0] TOREG_PC4 = 3'b010;
  localparam logic [2:0] TOREG_LUI = 3'b011;

  // Loads, stores and branches treat the 16-bit immediate as signed.
  function automatic logic ext_op(input instr_class_t cls);
    if (cls == C_LW || cls == C_SW || cls == C_BEQ) return EXT_SIGN;
    return EXT_ZERO;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction classifier: opcode/funct from the IR in,
// instruction class out. Anything not recognised is C_ILLEGAL.
module instr_decode
  import mips_defs::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] i_opcode,
  input  logic [OP_W-1:0] i_funct,
  output instr_class_t    o_class
);

  // Map opcode (and funct for R-type) to an instruction class
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred for codes the case does not list.
    o_class = C_ILLEGAL;
    case (i_opcode)
      OP_W'(OPC_RTYPE): begin
        case (i_funct)
          OP_W'(FN_ADDU): o_class = C_ADDU;
          OP_W'(FN_SUBU): o_class = C_SUBU;
          OP_W'(FN_JR):   o_class = C_JR;
          default:        o_class = C_ILLEGAL;
        endcase
      end
      OP_W'(OPC_ORI): o_class = C_ORI;
      OP_W'(OPC_LW):  o_class = C_LW;
      OP_W'(OPC_SW):  o_class = C_SW;
      OP_W'(OPC_BEQ): o_class = C_BEQ;
      OP_W'(OPC_LUI): o_class = C_LUI;
      OP_W'(OPC_J):   o_class = C_J;
      OP_W'(OPC_JAL): o_class = C_JAL;
      default:        o_class = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multi_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with a
// retired-instruction counter. Classification lives in instr_decode; this
// block sequences states and drives the datapath strobes and selects.
module multi_ctrl
  import mips_defs::*;
#(
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  input  logic            zero,
  output logic            PCWr,
  output logic            IRWr,
  output logic            GRFWr,
  output logic            DMWr,
  output logic [2:0]      NPCSel,
  output logic [2:0]      ALUOp,
  output logic            EXTOp,
  output logic [2:0]      RegDstSel,
  output logic [2:0]      ALUSrcSel,
  output logic [2:0]      toRegSel,
  output logic            instr_done,
  output logic [31:0]     retired
);

  logic [2:0]   r_state;
  logic [2:0]   w_next_state;
  instr_class_t w_class;
  instr_class_t r_class;
  instr_class_t w_cur_class;
  logic [31:0]  r_retired;

  instr_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .i_opcode (opcode),
    .i_funct  (funct),
    .o_class  (w_class)
  );

  // In DECODE the IR has just been loaded, so use the live decode; later
  // states use the copy captured on leaving DECODE.
  assign w_cur_class = (r_state == S_DECODE) ? w_class : r_class;

  // State register; reset lands in FETCH so the first edge fetches
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state is updated with <= so every register samples
    // its inputs from before the clock edge, independent of block order.
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next_state;
  end

  // Capture the instruction class at the end of DECODE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  r_class <= C_ILLEGAL;
    else if (r_state == S_DECODE)  r_class <= w_class;
  end

  // Next-state selection along each instruction's path
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        case (w_cur_class)
          C_ADDU, C_SUBU, C_ORI, C_LW, C_SW, C_BEQ, C_JR: w_next_state = S_EXEC;
          C_LUI, C_JAL:                                   w_next_state = S_WB;
          default:                                        w_next_state = S_FETCH;
        endcase
      end
      S_EXEC: begin
        case (w_cur_class)
          C_ADDU, C_SUBU, C_ORI: w_next_state = S_WB;
          C_LW, C_SW:            w_next_state = S_MEM;
          default:               w_next_state = S_FETCH;
        endcase
      end
      S_MEM:   w_next_state = (w_cur_class == C_LW) ? S_WB : S_FETCH;
      S_WB:    w_next_state = S_FETCH;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Retire pulse: high in whichever state ends the current instruction
  always_comb begin
    instr_done = 1'b0;
    if (reset_n) begin
      case (r_state)
        S_DECODE: instr_done = (w_cur_class == C_J) || (w_cur_class == C_ILLEGAL);
        S_EXEC:   instr_done = (w_cur_class == C_BEQ) || (w_cur_class == C_JR);
        S_MEM:    instr_done = (w_cur_class == C_SW);
        S_WB:     instr_done = 1'b1;
        default:  instr_done = 1'b0;
      endcase
    end
  end

  // Datapath strobes and selects; everything idles at 0/000 unless the
  // current state names it. Held low throughout reset, even though the
  // state register already sits in FETCH.
  always_comb begin
    PCWr      = 1'b0;
    IRWr      = 1'b0;
    GRFWr     = 1'b0;
    DMWr      = 1'b0;
    NPCSel    = NPC_PC4;
    ALUOp     = ALU_ADD;
    EXTOp     = EXT_ZERO;
    RegDstSel = RD_RT;
    ALUSrcSel = SRC_RD2;
    toRegSel  = TOREG_ALU;
    if (reset_n) begin
      if (r_state != S_FETCH) EXTOp = ext_op(w_cur_class);
      case (r_state)
        S_FETCH: begin
          IRWr   = 1'b1;
          PCWr   = 1'b1;
          NPCSel = NPC_PC4;
        end
        S_DECODE: begin
          if (w_cur_class == C_J) begin
            PCWr   = 1'b1;
            NPCSel = NPC_JUMP;
          end
        end
        S_EXEC: begin
          case (w_cur_class)
            C_SUBU, C_BEQ: ALUOp = ALU_SUB;
            C_ORI:         ALUOp = ALU_OR;
            default:       ALUOp = ALU_ADD;
          endcase
          if (w_cur_class == C_ORI || w_cur_class == C_LW || w_cur_class == C_SW)
            ALUSrcSel = SRC_IMM;
          if (w_cur_class == C_BEQ) begin
            PCWr   = zero;
            NPCSel = NPC_BRANCH;
          end
          if (w_cur_class == C_JR) begin
            PCWr   = 1'b1;
            NPCSel = NPC_REG;
          end
        end
        S_MEM: DMWr = (w_cur_class == C_SW);
        S_WB: begin
          GRFWr = 1'b1;
          case (w_cur_class)
            C_ADDU, C_SUBU: RegDstSel = RD_RD;
            C_LW:           toRegSel  = TOREG_DM;
            C_LUI:          toRegSel  = TOREG_LUI;
            C_JAL: begin
              RegDstSel = RD_RA;
              toRegSel  = TOREG_PC4;
              PCWr      = 1'b1;
              NPCSel    = NPC_JUMP;
            end
            default: begin
              RegDstSel = RD_RT;
              toRegSel  = TOREG_ALU;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  // Retired-instruction counter; wraps naturally at 32 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_retired <= 32'd0;
    else if (instr_done) r_retired <= r_retired + 32'd1;
  end

  assign retired = r_retired;

endmodule

// File: doc/multi_ctrl.md
MULTI_CTRL -- requirements
Module: multi_ctrl

Interface
REQ-001 The block SHALL have the parameter OP_W, default 6, giving the opcode and funct field width.
REQ-002 Ports: clk in 1, single clock, rising edge; reset_n in 1, asynchronous, active-low.
REQ-003 Ports: opcode in OP_W, instr[31:26]; funct in OP_W, instr[5:0]; zero in 1, ALU equal flag.
REQ-004 Ports: PCWr, IRWr, GRFWr, DMWr out 1 each, single-cycle write strobes.
REQ-005 Ports: NPCSel out 3, 000 PC+4, 001 branch, 010 j/jal target, 011 register.
REQ-006 Ports: ALUOp out 3, 000 add, 001 sub, 010 or; EXTOp out 1, 0 zero-extend, 1 sign-extend.
REQ-007 Ports: RegDstSel out 3, 000 rt, 001 rd, 010 literal 31.
REQ-008 Ports: ALUSrcSel out 3, 000 GRF rd2, 001 extended immediate.
REQ-009 Ports: toRegSel out 3, 000 ALU result, 001 DM read data, 010 PC+4, 011 imm<<16.
REQ-010 Ports: instr_done out 1, retire pulse; retired out 32, retired-instruction count.

Function
REQ-011 Moore FSM states: FETCH, DECODE, EXEC, MEM, WB; one state per cycle.
REQ-012 FETCH SHALL assert IRWr=1, PCWr=1, NPCSel=000, then go to DECODE.
REQ-013 DECODE SHALL classify opcode/funct (latched by the IR) into ADDU, SUBU, ORI, LW, SW, BEQ, LUI, J, JAL, JR or ILLEGAL.
REQ-014 Paths: ADDU/SUBU/ORI D->EXEC->WB; LW D->EXEC->MEM->WB; SW D->EXEC->MEM; BEQ, JR D->EXEC; LUI, JAL D->WB; J, ILLEGAL D->FETCH.
REQ-015 Latency from FETCH to retire: J 2, BEQ/JR/LUI/JAL 3, ADDU/SUBU/ORI/SW 4, LW 5 cycles.
REQ-016 J SHALL assert PCWr=1, NPCSel=010 in DECODE; ILLEGAL SHALL assert no write strobe.
REQ-017 EXEC SHALL drive ALUOp (ADDU 000, SUBU 001, ORI 010, LW/SW 000, BEQ 001) and ALUSrcSel (001 for ORI/LW/SW, else 000).
REQ-018 EXEC for BEQ SHALL assert PCWr=zero with NPCSel=001; EXEC for JR SHALL assert PCWr=1 with NPCSel=011.
REQ-019 EXTOp SHALL be 1 for LW, SW and BEQ, else 0.
REQ-020 MEM SHALL assert DMWr=1 for SW only.
REQ-021 WB SHALL assert GRFWr=1 with RegDstSel/toRegSel: ADDU/SUBU 001/000, ORI 000/000, LW 000/001, LUI 000/011, JAL 010/010.
REQ-022 WB for JAL SHALL also assert PCWr=1, NPCSel=010; the link value is PC+4 of the JAL.
REQ-023 Every write strobe SHALL be high for exactly one cycle per instruction and 0 in every other state.
REQ-024 Select outputs not named for the current state SHALL be 000.
REQ-025 instr_done SHALL pulse 1 in the final state of each instruction path, including ILLEGAL.
REQ-026 retired SHALL increment by 1 on each instr_done; it wraps 0xFFFFFFFF->0.

Reset
REQ-027 reset_n=0 SHALL asynchronously force state FETCH, all strobes 0, all selects 000, and retired 0.
REQ-028 Reset mid-instruction SHALL abandon the instruction with no partial write.
REQ-029 The first rising edge after reset_n deasserts SHALL execute FETCH.

Structure
REQ-030 State codes, instruction-class codes, opcode/funct constants and the select encodings SHALL live in shared package mips_defs, which the datapath muxes also use.
REQ-031 Classification SHALL be the combinational sub-module instr_decode (opcode, funct -> class); multi_ctrl holds only the FSM and counter.

Verification
REQ-032 Scenario: reset, addu (op 000000, funct 100001) -> FETCH, DECODE, EXEC, WB; GRFWr=1 in cycle 4 with RegDstSel=001, toRegSel=000; retired=1.
REQ-033 Scenario: lw (op 100011) -> 5 cycles; EXEC ALUSrcSel=001, EXTOp=1; WB toRegSel=001, RegDstSel=000; DMWr stays 0.
REQ-034 Scenario: beq (op 000100) with zero=1, then again with zero=0 -> PCWr=1/NPCSel=001 in EXEC for the first, PCWr=0 for the second; both retire after 3 cycles.
REQ-035 Scenario: jal (op 000011) -> WB has GRFWr=1, RegDstSel=010, toRegSel=010, PCWr=1, NPCSel=010.
REQ-036 Scenario: reset_n low during MEM of sw -> DMWr never asserts, retired unchanged at 0, FETCH follows.
REQ-037 Scenario: opcode 111111 -> no write strobe after FETCH, instr_done in DECODE, back to FETCH; preset retired 0xFFFFFFFF wraps to 0.
